// File: rtl/down_timer.sv
// Loadable down-counter with one-shot / auto-reload modes, enable-driven hold,
// abort, and a saturating expiry-event counter.
module down_timer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ECNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              load_auto,
  input  logic              abort,
  output logic [WIDTH-1:0]  out,
  output logic              expired,
  output logic              busy,
  output logic [ECNT_W-1:0] expire_count
);

  localparam logic [ECNT_W-1:0] ECNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    reload_q, reload_d;
  logic                auto_q, auto_d;
  logic                expired_q, expired_d;
  logic [ECNT_W-1:0]   ecnt_q, ecnt_d;
  logic                expire_evt;

  // State and datapath registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      reload_q  <= '0;
      auto_q    <= 1'b0;
      expired_q <= 1'b0;
      ecnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      auto_q    <= auto_d;
      expired_q <= expired_d;
      ecnt_q    <= ecnt_d;
    end
  end

  // Next-state logic; abort outranks expiry while busy, load outranks abort when idle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    reload_d   = reload_q;
    auto_d     = auto_q;
    expire_evt = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_valid) begin
          if (load_value != '0) begin
            cnt_d    = load_value;
            reload_d = load_value;
            auto_d   = load_auto;
            state_d  = RUN;
          end else begin
            expire_evt = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (!enable) begin
          state_d = HOLD;
        end else if (cnt_q > WIDTH'(1)) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else begin
          expire_evt = 1'b1;
          if (auto_q) begin
            cnt_d = reload_q;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (enable) begin
          state_d = RUN;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    expired_d = expire_evt;
    ecnt_d    = (expire_evt && (ecnt_q != ECNT_MAX)) ? ecnt_q + ECNT_W'(1) : ecnt_q;
  end

  assign out          = cnt_q;
  assign expired      = expired_q;
  assign expire_count = ecnt_q;
  assign busy         = (state_q == RUN) || (state_q == HOLD);
  assign load_ready   = (state_q == IDLE);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a behavioural model.
module tb_down_timer;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ECNT_W = 8;
  localparam int          ECNT_SAT = (1 << ECNT_W) - 1;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              load_valid;
  logic              load_ready;
  logic [WIDTH-1:0]  load_value;
  logic              load_auto;
  logic              abort;
  logic [WIDTH-1:0]  out;
  logic              expired;
  logic              busy;
  logic [ECNT_W-1:0] expire_count;

  down_timer #(.WIDTH(WIDTH), .ECNT_W(ECNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_value   (load_value),
    .load_auto    (load_auto),
    .abort        (abort),
    .out          (out),
    .expired      (expired),
    .busy         (busy),
    .expire_count (expire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural reference: a timer is either idle or busy (running or paused).
  bit m_busy, m_paused, m_auto, m_pulse;
  int m_cnt, m_reload, m_events;

  function automatic void model_step(input bit rst, input bit en, input bit lv,
                                     input int val, input bit au, input bit ab);
    m_pulse = 1'b0;
    if (rst) begin
      m_busy = 0; m_paused = 0; m_auto = 0; m_cnt = 0; m_reload = 0; m_events = 0;
    end else if (!m_busy) begin
      if (lv) begin
        if (val == 0) begin
          m_pulse = 1'b1; m_events++;
        end else begin
          m_busy = 1; m_paused = 0; m_cnt = val; m_reload = val; m_auto = au;
        end
      end
    end else if (ab) begin
      m_busy = 0; m_cnt = 0;
    end else if (m_paused) begin
      if (en) m_paused = 0;
    end else if (!en) begin
      m_paused = 1;
    end else if (m_cnt > 1) begin
      m_cnt = m_cnt - 1;
    end else begin
      m_pulse = 1'b1; m_events++;
      if (m_auto) m_cnt = m_reload;
      else begin m_cnt = 0; m_busy = 0; end
    end
  endfunction

  // Apply one cycle of inputs; outputs are sampled 1ns after the edge.
  task automatic cyc(input bit rst, input bit en, input bit lv, input int val,
                     input bit au, input bit ab);
    reset = rst; enable = en; load_valid = lv; load_value = WIDTH'(val);
    load_auto = au; abort = ab;
    @(posedge clk);
    model_step(rst, en, lv, val, au, ab);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out"},   int'(out), m_cnt);
    check({tag, ".exp"},   int'(expired), int'(m_pulse));
    check({tag, ".busy"},  int'(busy), int'(m_busy));
    check({tag, ".rdy"},   int'(load_ready), int'(!m_busy));
    check({tag, ".ecnt"},  int'(expire_count), (m_events > ECNT_SAT) ? ECNT_SAT : m_events);
  endtask

  typedef struct {
    bit rst; bit en; bit lv; int val; bit au; bit ab;
    int e_out; bit e_exp; bit e_busy; bit e_rdy; int e_ecnt;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  int pulses;
  int exp_out;

  initial begin
    reset = 1'b1; enable = 1'b0; load_valid = 1'b0; load_value = '0;
    load_auto = 1'b0; abort = 1'b0;

    //          rst en lv val au ab | out exp busy rdy ecnt
    tbl[0]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0};
    tbl[2]  = '{0, 1, 1, 3, 0, 0,   3, 0, 1, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 0,   2, 0, 1, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 0,   0, 1, 0, 1, 1};
    tbl[6]  = '{0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 1};
    tbl[7]  = '{0, 0, 1, 0, 1, 0,   0, 1, 0, 1, 2};
    tbl[8]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 2};
    tbl[9]  = '{0, 0, 1, 2, 0, 0,   2, 0, 1, 0, 2};
    tbl[10] = '{0, 0, 0, 0, 0, 0,   2, 0, 1, 0, 2};
    tbl[11] = '{0, 1, 0, 0, 0, 0,   2, 0, 1, 0, 2};
    tbl[12] = '{0, 1, 0, 0, 0, 0,   1, 0, 1, 0, 2};
    tbl[13] = '{0, 1, 0, 0, 0, 1,   0, 0, 0, 1, 2};
    tbl[14] = '{0, 1, 1, 5, 0, 1,   5, 0, 1, 0, 2};
    tbl[15] = '{0, 1, 1, 9, 0, 0,   4, 0, 1, 0, 2};
    tbl[16] = '{1, 1, 1, 7, 1, 0,   0, 0, 0, 1, 0};
    tbl[17] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0};

    for (int i = 0; i < NVEC; i++) begin
      cyc(tbl[i].rst, tbl[i].en, tbl[i].lv, tbl[i].val, tbl[i].au, tbl[i].ab);
      check($sformatf("vec%0d.out", i),  int'(out), tbl[i].e_out);
      check($sformatf("vec%0d.exp", i),  int'(expired), int'(tbl[i].e_exp));
      check($sformatf("vec%0d.busy", i), int'(busy), int'(tbl[i].e_busy));
      check($sformatf("vec%0d.rdy", i),  int'(load_ready), int'(tbl[i].e_rdy));
      check($sformatf("vec%0d.ecnt", i), int'(expire_count), tbl[i].e_ecnt);
    end

    // Auto-reload period 4 over 12 enabled cycles.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 4, 1, 0);
    check("auto.first", int'(out), 4);
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 1, 0, 0, 0, 0);
      exp_out = (k % 4 == 0) ? 4 : 4 - (k % 4);
      check($sformatf("auto.out%0d", k), int'(out), exp_out);
      check($sformatf("auto.exp%0d", k), int'(expired), int'(k % 4 == 0));
      pulses += int'(expired);
    end
    check("auto.pulses", pulses, 3);
    check("auto.ecnt", int'(expire_count), 3);
    check("auto.busy", int'(busy), 1);
    cyc(0, 1, 0, 0, 0, 1);
    check("auto.abort_busy", int'(busy), 0);

    // Hold for three cycles at 4, then resume without a decrement on the resume edge.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 5, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("hold.pre", int'(out), 4);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      check($sformatf("hold.out%0d", k), int'(out), 4);
      check($sformatf("hold.busy%0d", k), int'(busy), 1);
    end
    cyc(0, 1, 0, 0, 0, 0);
    check("hold.resume", int'(out), 4);
    for (int k = 3; k >= 0; k--) begin
      cyc(0, 1, 0, 0, 0, 0);
      check($sformatf("hold.run%0d", k), int'(out), k);
      check($sformatf("hold.exp%0d", k), int'(expired), int'(k == 0));
    end
    check("hold.ecnt", int'(expire_count), 1);

    // Reset at out==1 discards the pending expiry.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 2, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("rstmid.pre", int'(out), 1);
    cyc(1, 1, 0, 0, 0, 0);
    check("rstmid.exp0", int'(expired), 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("rstmid.exp1", int'(expired), 0);
    check("rstmid.out", int'(out), 0);
    check("rstmid.ecnt", int'(expire_count), 0);

    // 300 zero-value loads saturate the event counter.
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      cyc(0, 0, 1, 0, 1, 0);
      pulses += int'(expired);
      if (busy) check("sat.busy", int'(busy), 0);
    end
    check("sat.pulses", pulses, 300);
    check("sat.ecnt", int'(expire_count), ECNT_SAT);
    check("sat.busy_end", int'(busy), 0);
    cyc(0, 0, 1, 0, 0, 0);
    check("sat.hold", int'(expire_count), ECNT_SAT);

    // Randomized traffic against the reference model.
    cyc(1, 0, 0, 0, 0, 0);
    check_model("rnd.init");
    for (int k = 0; k < 1500; k++) begin
      cyc(($urandom_range(0, 63) == 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) == 0),
          (($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 9))),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0));
      check_model($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
